// File: rtl/pdm_transmitter.sv
// PDM audio transmitter: PCM sample FIFO, first-order sigma-delta modulator, bit clock generator.
// Optional macro PDM_TX_UNDERRUN_CNT_EN adds a saturating underrun counter output.
module pdm_transmitter #(
  parameter int SAMPLE_W   = 16,
  parameter int CLK_DIV    = 40,
  parameter int OSR        = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [SAMPLE_W-1:0] s_data_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  output logic                pdm_clk_o,
  output logic                pdm_o,
  output logic                aud_sd_o,
  output logic                busy_o,
  output logic                underrun_o
`ifdef PDM_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]         underrun_cnt_o
`endif
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(OSR);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(OSR - 1);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    divider_q, divider_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0] acc_q, acc_d;
  logic [SAMPLE_W-1:0] cur_q, cur_d;
  logic                pdm_q, pdm_d;
  logic                pdm_clk_q, pdm_clk_d;
  logic                aud_sd_q, aud_sd_d;
  logic                underrun_q, underrun_d;

  logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                fifo_empty, fifo_full, push, pop;
  logic [SAMPLE_W-1:0] fifo_rd;

  logic                bit_tick, frame_end;
  logic [SAMPLE_W-1:0] offset_u;
  logic [SAMPLE_W:0]   sum;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_FULL);
  assign s_ready_o  = ~fifo_full;
  assign push       = s_valid_i & ~fifo_full;
  assign fifo_rd    = mem_q[rd_ptr_q];

  assign bit_tick  = (state_q != IDLE) && (divider_q == DIV_LAST);
  assign frame_end = bit_tick && (bit_cnt_q == BIT_LAST);

  // Offset-binary view of the sample so the carry density tracks the signed value.
  assign offset_u = {~cur_q[SAMPLE_W-1], cur_q[SAMPLE_W-2:0]};
  assign sum      = {1'b0, acc_q} + {1'b0, offset_u};

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    state_d    = state_q;
    divider_d  = divider_q;
    bit_cnt_d  = bit_cnt_q;
    acc_d      = acc_q;
    cur_d      = cur_q;
    pdm_d      = pdm_q;
    underrun_d = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        pdm_d = 1'b0;
        if (en_i && !fifo_empty) begin
          state_d   = RUN;
          pop       = 1'b1;
          cur_d     = fifo_rd;
          divider_d = '0;
          bit_cnt_d = '0;
          acc_d     = '0;
        end
      end
      RUN, STOP: begin
        state_d   = en_i ? RUN : STOP;
        divider_d = bit_tick ? '0 : divider_q + DIV_W'(1);
        if (bit_tick) begin
          acc_d     = sum[SAMPLE_W-1:0];
          pdm_d     = sum[SAMPLE_W];
          bit_cnt_d = frame_end ? '0 : bit_cnt_q + BIT_W'(1);
        end
        // A stopping frame drains to IDLE; a running frame reloads or repeats on underrun.
        if (frame_end) begin
          if (state_q == STOP && !en_i) begin
            state_d   = IDLE;
            pdm_d     = 1'b0;
            divider_d = '0;
          end else if (!fifo_empty) begin
            pop   = 1'b1;
            cur_d = fifo_rd;
          end else begin
            underrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    pdm_clk_d = (state_d != IDLE) && (divider_d < DIV_HALF);
    aud_sd_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      divider_q  <= '0;
      bit_cnt_q  <= '0;
      acc_q      <= '0;
      cur_q      <= '0;
      pdm_q      <= 1'b0;
      pdm_clk_q  <= 1'b0;
      aud_sd_q   <= 1'b0;
      underrun_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      divider_q  <= divider_d;
      bit_cnt_q  <= bit_cnt_d;
      acc_q      <= acc_d;
      cur_q      <= cur_d;
      pdm_q      <= pdm_d;
      pdm_clk_q  <= pdm_clk_d;
      aud_sd_q   <= aud_sd_d;
      underrun_q <= underrun_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= s_data_i;
  end

`ifdef PDM_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (state_q == IDLE && state_d == RUN) ucnt_d = '0;
    else if (underrun_d && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ucnt_q <= '0;
    else         ucnt_q <= ucnt_d;
  end

  assign underrun_cnt_o = ucnt_q;
`endif

  assign pdm_o      = pdm_q;
  assign pdm_clk_o  = pdm_clk_q;
  assign aud_sd_o   = aud_sd_q;
  assign busy_o     = (state_q != IDLE);
  assign underrun_o = underrun_q;

endmodule
